// File: rtl/program_mem_if.sv
// Loader byte-stream and fetch-port signals of the loadable program memory.
// The master side is the loader/fetch logic; the slave side is program_mem.
interface program_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              load_en;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic [ADDR_W:0]   load_count;
    logic              load_done;
    logic              busy;
    logic              fetch_en;
    logic [ADDR_W-1:0] addr_p;
    logic [DATA_W-1:0] out_prom;
    logic              out_valid;

    modport master (
        output load_en, in_valid, in_byte, fetch_en, addr_p,
        input  in_ready, load_count, load_done, busy, out_prom, out_valid
    );

    modport slave (
        input  load_en, in_valid, in_byte, fetch_en, addr_p,
        output in_ready, load_count, load_done, busy, out_prom, out_valid
    );
endinterface

// File: rtl/program_mem.sv
// Run-time loadable program RAM: MSB-first byte loader assembles words,
// fetch port returns a registered word one cycle after fetch_en in IDLE.
module program_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input logic          clk,
    input logic          rst,
    program_mem_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W:0] FULL      = (ADDR_W + 1)'(DEPTH);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state;
    logic [BC_W-1:0]   byte_cnt;
    logic [DATA_W-1:0] asm_reg;
    logic [ADDR_W:0]   count_q;
    logic              done_q;
    logic [DATA_W-1:0] prom_q;
    logic              valid_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              accept;
    logic              word_wr;
    logic [DATA_W-1:0] word_next;

    assign ready     = (state == LOAD) && bus.load_en && (count_q < FULL);
    assign accept    = ready && bus.in_valid;
    assign word_wr   = accept && (byte_cnt == LAST_BYTE);
    assign word_next = (asm_reg << 8) | DATA_W'(bus.in_byte);

    assign bus.in_ready   = ready;
    assign bus.load_count = count_q;
    assign bus.load_done  = done_q;
    assign bus.busy       = (state == LOAD);
    assign bus.out_prom   = prom_q;
    assign bus.out_valid  = valid_q;

    // load_count doubles as the write pointer; it saturates at DEPTH, so no wrap.
    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[count_q[ADDR_W-1:0]] <= word_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            asm_reg  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            prom_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.fetch_en) begin
                        prom_q  <= mem[bus.addr_p];
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                    if (bus.load_en) begin
                        state    <= LOAD;
                        byte_cnt <= '0;
                        count_q  <= '0;
                        done_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    valid_q <= 1'b0;
                    if (!bus.load_en) begin
                        state    <= IDLE;
                        done_q   <= 1'b1;
                        byte_cnt <= '0;
                    end else if (accept) begin
                        asm_reg <= word_next;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            count_q  <= count_q + 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_program_mem.sv
// Randomised bench for program_mem: a 256-word and a 4-word instance share one
// stimulus stream and are each compared against a word-level reference model.
module tb_program_mem;
    logic       clk;
    logic       rst;
    logic       load_en;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       fetch_en;
    logic [7:0] addr;

    program_mem_if #(.DATA_W(16), .ADDR_W(8)) bus8 ();
    program_mem_if #(.DATA_W(16), .ADDR_W(2)) bus2 ();

    assign bus8.load_en  = load_en;
    assign bus8.in_valid = in_valid;
    assign bus8.in_byte  = in_byte;
    assign bus8.fetch_en = fetch_en;
    assign bus8.addr_p   = addr;
    assign bus2.load_en  = load_en;
    assign bus2.in_valid = in_valid;
    assign bus2.in_byte  = in_byte;
    assign bus2.fetch_en = fetch_en;
    assign bus2.addr_p   = addr[1:0];

    program_mem #(.DATA_W(16), .ADDR_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    program_mem #(.DATA_W(16), .ADDR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: index 0 is the 256-word instance, index 1 the 4-word one.
    logic [15:0] mref [2][256];
    int          m_cnt   [2];
    bit          m_done  [2];
    bit          m_busy  [2];
    bit          m_ov    [2];
    logic [15:0] m_out   [2];
    int          m_npend [2];
    logic [7:0]  m_hi    [2];

    function automatic int dep(input int i);
        return (i == 0) ? 256 : 4;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_done[i] = 0; m_busy[i] = 0;
            m_ov[i] = 0; m_out[i] = '0; m_npend[i] = 0;
        end
    endfunction

    function automatic bit exp_ready(input int i);
        return m_busy[i] && load_en && (m_cnt[i] < dep(i));
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_done[i] = 0; m_busy[i] = 0;
                m_ov[i] = 0; m_out[i] = '0; m_npend[i] = 0;
            end else if (!m_busy[i]) begin
                if (fetch_en) begin
                    m_out[i] = mref[i][int'(addr) % dep(i)];
                    m_ov[i]  = 1;
                end else begin
                    m_ov[i] = 0;
                end
                if (load_en) begin
                    m_busy[i] = 1; m_cnt[i] = 0; m_done[i] = 0; m_npend[i] = 0;
                end
            end else begin
                m_ov[i] = 0;
                if (!load_en) begin
                    m_busy[i] = 0; m_done[i] = 1; m_npend[i] = 0;
                end else if (in_valid && m_cnt[i] < dep(i)) begin
                    if (m_npend[i] == 0) begin
                        m_hi[i]    = in_byte;
                        m_npend[i] = 1;
                    end else begin
                        mref[i][m_cnt[i]] = {m_hi[i], in_byte};
                        m_cnt[i]++;
                        m_npend[i] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic check_outputs();
        check("load_count8", 32'(bus8.load_count), 32'(m_cnt[0]));
        check("load_done8",  32'(bus8.load_done),  32'(m_done[0]));
        check("busy8",       32'(bus8.busy),       32'(m_busy[0]));
        check("out_valid8",  32'(bus8.out_valid),  32'(m_ov[0]));
        check("out_prom8",   32'(bus8.out_prom),   32'(m_out[0]));
        check("load_count2", 32'(bus2.load_count), 32'(m_cnt[1]));
        check("load_done2",  32'(bus2.load_done),  32'(m_done[1]));
        check("busy2",       32'(bus2.busy),       32'(m_busy[1]));
        check("out_valid2",  32'(bus2.out_valid),  32'(m_ov[1]));
        check("out_prom2",   32'(bus2.out_prom),   32'(m_out[1]));
    endtask

    // One clock: check combinational in_ready, take the edge, check registers.
    task automatic step();
        #1;
        check("in_ready8", 32'(bus8.in_ready), 32'(exp_ready(0)));
        check("in_ready2", 32'(bus2.in_ready), 32'(exp_ready(1)));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        load_en = 0; in_valid = 0; in_byte = '0; fetch_en = 0; addr = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        #1;
        check_outputs();
        step();
        rst = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1; in_byte = b;
        step();
    endtask

    task automatic fetch(input logic [7:0] a);
        fetch_en = 1; addr = a;
        step();
        fetch_en = 0;
    endtask

    logic [7:0]  basic_bytes [6];
    logic [15:0] basic_words [3];
    int          guard;

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++)
                mref[i][j] = '0;
        basic_bytes = '{8'h84, 8'h04, 8'h85, 8'h05, 8'h11, 8'h00};
        basic_words = '{16'h8404, 16'h8505, 16'h1100};
        idle_inputs();
        rst = 0;
        model_reset();
        #2;

        // Reset and empty fetch
        do_reset();
        check("rst_in_ready", 32'(bus8.in_ready), 32'd0);
        fetch(8'd0);
        check("empty_fetch_valid", 32'(bus8.out_valid), 32'd1);
        check("empty_fetch_word",  32'(bus8.out_prom),  32'h0000);

        // Basic load and read
        load_en = 1;
        step();
        foreach (basic_bytes[k]) send_byte(basic_bytes[k]);
        in_valid = 0; load_en = 0;
        step();
        check("basic_count", 32'(bus8.load_count), 32'd3);
        check("basic_done",  32'(bus8.load_done),  32'd1);
        for (int k = 0; k < 3; k++) begin
            fetch(8'(k));
            check("basic_word", 32'(bus8.out_prom), 32'(basic_words[k]));
        end
        step();

        // Backpressure and gaps over a 4-word load
        load_en = 1;
        step();
        guard = 0;
        while (m_cnt[0] < 4 && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = 8'($urandom);
            step();
            guard++;
        end
        check("bp_count", 32'(bus8.load_count), 32'd4);
        in_valid = 0; load_en = 0;
        step();
        for (int k = 0; k < 4; k++) fetch(8'(k));

        // Partial word: 1.5 words then exit
        load_en = 1;
        step();
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        in_valid = 0; load_en = 0;
        step();
        check("partial_count", 32'(bus8.load_count), 32'd1);
        fetch(8'd1);

        // Full: five words into the 4-word instance
        load_en = 1;
        step();
        for (int k = 0; k < 10; k++) send_byte(8'($urandom));
        in_valid = 0;
        step();
        check("full_count2", 32'(bus2.load_count), 32'd4);
        check("full_ready2", 32'(bus2.in_ready),   32'd0);
        check("full_count8", 32'(bus8.load_count), 32'd5);
        load_en = 0;
        step();
        for (int k = 0; k < 5; k++) fetch(8'(k));

        // Fetch while busy is ignored
        load_en = 1;
        step();
        fetch(8'd2);
        check("load_fetch_valid", 32'(bus8.out_valid), 32'd0);
        load_en = 0;
        step();

        // Reset after the first byte of word 2
        load_en = 1;
        step();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom));
        in_valid = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        check("midrst_busy",  32'(bus8.busy),       32'd0);
        check("midrst_count", 32'(bus8.load_count), 32'd0);
        check("midrst_done",  32'(bus8.load_done),  32'd0);
        load_en = 0;
        step();
        rst = 0;
        fetch(8'd0);
        fetch(8'd1);

        // Random mixed traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) load_en = ~load_en;
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = 8'($urandom);
            fetch_en = 1'($urandom_range(0, 1));
            addr     = 8'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        step();
        for (int k = 0; k < 8; k++) fetch(8'(k));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
